flag_event_gen: RTL and testbench
=================================

// Module: flag_event_gen
// PURPOSE
//  Source side of the LED flag interface. Watches one asynchronous status level (link error, FIFO overflow, ...).
//  Issues one-cycle start/stop pulses to the downstream LED flag driver.
//  Qualifies the status against glitches and keeps the flag lit for a minimum time.
//  Sits between DIF status logic and the flag driver; all logic in the 80 MHz Clk_In domain.
// PARAMETERS
//  QUAL_CYCLES  16'd800       cycles In_Status must stay high before flagging (10 us @ 80 MHz); >= 1
//  HOLD_CYCLES  28'h4C4B400   min cycles flag stays lit after status drops (1 s @ 80 MHz); >= 1
//  CNT_W        16            width of event counter
// PORTS
//  Clk_In               in   1      80 MHz clock
//  Rst_N                in   1      async reset, active low
//  In_Status            in   1      async status level, 1 = fault/condition present
//  In_Clear             in   1      sync one-cycle clear request from slow control
//  Out_Start_Light      out  1      one-cycle pulse: light the flag
//  Out_Stop_Extinguish  out  1      one-cycle pulse: extinguish the flag
//  Out_Flag_Active      out  1      level, 1 while state is ACTIVE or HOLD
//  Out_Event_Cnt        out  CNT_W  count of start pulses issued, saturating
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (Rst_N, low = reset); clock is Clk_In.
//  Reset: every output 0, state IDLE, counters 0, armed = 1.
//  Resetting mid-operation aborts without a stop pulse; the downstream driver shares Rst_N.
//  In_Status passes a 2-FF synchronizer -> sts. All outputs are registered.
//  Pulses are high for exactly one cycle, in the first cycle after the state edge that causes them.
//  States:
//   IDLE: armed clears to 0 on In_Clear (see below); armed sets to 1 when sts == 0.
//     If sts == 1 && armed -> QUALIFY, qcnt = 0.
//   QUALIFY: sts == 0 -> IDLE (no pulse).
//     Otherwise qcnt++; at qcnt == QUAL_CYCLES-1 -> ACTIVE, Out_Start_Light pulse.
//   ACTIVE: sts == 0 -> HOLD, hcnt = 0.
//   HOLD: sts == 1 -> ACTIVE, no new start pulse (retrigger), hcnt = 0.
//     At hcnt == HOLD_CYCLES-1 -> IDLE, Out_Stop_Extinguish pulse.
//  In_Clear in ACTIVE or HOLD -> IDLE, Out_Stop_Extinguish pulse, armed = 0.
//    sts must then be seen low before requalification.
//  In_Clear in IDLE or QUALIFY: ignored.
//  Priority: In_Clear > hold expiry > sts change.
//    Simultaneous clear + expiry gives exactly one stop pulse.
//  Latency: In_Status held high from edge 0 -> start pulse after edge QUAL_CYCLES+3.
//  Start and stop are never high together. Every start is followed by exactly one stop before the next start.
//  Out_Event_Cnt: +1 on each start pulse; holds at 2^CNT_W-1; cleared only by Rst_N.
//  Counter widths: qcnt 16 b, hcnt 28 b; compare with ==, no wrap possible.
// CONFIGURATION
//  FLAG_STICKY_EN defined:
//    ACTIVE ignores sts == 0; HOLD is unreachable.
//    Stop is issued only by In_Clear, so a latched fault stays lit until acknowledged.
//  FLAG_STICKY_EN undefined: auto-extinguish via HOLD as above.
// STRUCTURE
//  Shared package/header (flag_pkg.vh): state encodings IDLE/QUALIFY/ACTIVE/HOLD (4 b).
//    Also TIME_10US = 16'd800, TIME_05S = 28'h2625A00, TIME_1S = 28'h4C4B400 (80 MHz).
//  Sub-module: flag_sync_2ff (2-FF synchronizer, async active-low reset to 0).
//  FSM, counters and output registers live in flag_event_gen.
// TESTING (bench overrides QUAL_CYCLES=4, HOLD_CYCLES=10)
//  1. In_Status high 3 cycles then low -> no pulses, Out_Event_Cnt stays 0.
//  2. In_Status held high from edge 0 -> Out_Start_Light one cycle after edge 7.
//     Then Out_Flag_Active = 1 and Out_Event_Cnt = 1.
//  3. After 2, drop In_Status -> Out_Stop_Extinguish exactly 10 cycles after entering HOLD; Out_Flag_Active = 0.
//  4. After 2, drop In_Status 5 cycles, raise again -> back to ACTIVE, no second start, no stop pulse.
//  5. In ACTIVE with In_Status high, pulse In_Clear -> one stop pulse, IDLE.
//     No new start until In_Status goes low then high again (second start 7 edges after re-rise).
//  6. In_Clear on the same cycle as hold expiry -> exactly one stop pulse.
//     With FLAG_STICKY_EN: step 3 gives no stop pulse; only In_Clear stops.

Source files
------------

// File: rtl/flag_event_gen_pkg.sv
// Package for the flag event generator.
// It holds the FSM state encoding and the standard 80 MHz time constants.
// There are no ports.
package flag_event_gen_pkg;

  // One bit per state, so decoding never needs to compare a full encoded value
  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StQualify = 4'b0010,
    StActive  = 4'b0100,
    StHold    = 4'b1000
  } flag_state_e;

  // Cycle counts at 80 MHz
  localparam logic [15:0] TIME_10US = 16'd800;
  localparam logic [27:0] TIME_05S  = 28'h2625A00;
  localparam logic [27:0] TIME_1S   = 28'h4C4B400;

endpackage

// File: rtl/flag_event_gen_if.sv
// Flag interface between the status source and the LED flag driver.
//   In_Status           async status level (1 = condition present)
//   In_Clear            one-cycle clear request
//   Out_Start_Light     one-cycle pulse: light the flag
//   Out_Stop_Extinguish one-cycle pulse: extinguish the flag
//   Out_Flag_Active     level, flag currently lit
//   Out_Event_Cnt       saturating count of start pulses
// The master modport is the generator side, and the slave modport is the stimulus/driver side.
interface flag_event_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             In_Status;
  logic             In_Clear;
  logic             Out_Start_Light;
  logic             Out_Stop_Extinguish;
  logic             Out_Flag_Active;
  logic [CNT_W-1:0] Out_Event_Cnt;

  modport master (
    input  In_Status,
    input  In_Clear,
    output Out_Start_Light,
    output Out_Stop_Extinguish,
    output Out_Flag_Active,
    output Out_Event_Cnt
  );

  modport slave (
    output In_Status,
    output In_Clear,
    input  Out_Start_Light,
    input  Out_Stop_Extinguish,
    input  Out_Flag_Active,
    input  Out_Event_Cnt
  );
endinterface

// File: rtl/flag_event_gen_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
//   Clk_In   destination clock
//   Rst_N    async reset, active low (both flops clear to 0)
//   In_Async asynchronous input level
//   Out_Sync synchronized level, two Clk_In edges late
module flag_event_gen_sync_2ff (
  input  logic Clk_In,
  input  logic Rst_N,
  input  logic In_Async,
  output logic Out_Sync
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= In_Async;
      sync_q <= meta_q;
    end
  end

  assign Out_Sync = sync_q;
endmodule

// File: rtl/flag_event_gen.sv
// Source side of the LED flag interface.
// The block qualifies an asynchronous status level against glitches.
// It issues one-cycle start/stop pulses and keeps the flag lit for a minimum hold time.
//   Clk_In    80 MHz clock
//   Rst_N     async reset, active low (aborts silently, no stop pulse)
//   flag_bus  flag_event_gen_if.master: In_Status, In_Clear in; start/stop pulses,
//             flag-active level and saturating event count out (all registered)
// Parameters: QUAL_CYCLES, HOLD_CYCLES (>= 1) and CNT_W.
// Build option: with FLAG_STICKY_EN defined, a lit flag ignores status drops.
// In that build the flag is extinguished only by In_Clear.
module flag_event_gen
  import flag_event_gen_pkg::*;
#(
  parameter logic [15:0] QUAL_CYCLES = TIME_10US,
  parameter logic [27:0] HOLD_CYCLES = TIME_1S,
  parameter int unsigned CNT_W       = 16
) (
  input logic              Clk_In,
  input logic              Rst_N,
  flag_event_gen_if.master flag_bus
);
  localparam logic [15:0]      QUAL_LAST = QUAL_CYCLES - 16'd1;
  localparam logic [27:0]      HOLD_LAST = HOLD_CYCLES - 28'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sts;
  flag_state_e      state_q;
  logic [15:0]      qcnt_q;
  logic [27:0]      hcnt_q;
  logic             armed_q;
  logic             start_q;
  logic             stop_q;
  logic             active_q;
  logic [CNT_W-1:0] event_cnt_q;

  flag_event_gen_sync_2ff u_sync (
    .Clk_In   (Clk_In),
    .Rst_N    (Rst_N),
    .In_Async (flag_bus.In_Status),
    .Out_Sync (sts)
  );

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q     <= StIdle;
      qcnt_q      <= '0;
      hcnt_q      <= '0;
      armed_q     <= 1'b1;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      active_q    <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // After a clear, status must be seen low before the block re-arms
          if (!sts) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= StQualify;
            qcnt_q  <= '0;
          end
        end
        StQualify: begin
          if (!sts) begin
            state_q <= StIdle;
          end else if (qcnt_q == QUAL_LAST) begin
            state_q  <= StActive;
            start_q  <= 1'b1;
            active_q <= 1'b1;
            if (event_cnt_q != CNT_MAX) event_cnt_q <= event_cnt_q + 1'b1;
          end else begin
            qcnt_q <= qcnt_q + 16'd1;
          end
        end
        StActive: begin
          if (flag_bus.In_Clear) begin
            state_q  <= StIdle;
            stop_q   <= 1'b1;
            active_q <= 1'b0;
            armed_q  <= 1'b0;
          end
`ifdef FLAG_STICKY_EN
          // Latched fault: a status drop is ignored until acknowledged
`else
          else if (!sts) begin
            state_q <= StHold;
            hcnt_q  <= '0;
          end
`endif
        end
        StHold: begin
          // Clear outranks expiry, so a coincident pair still gives a single stop
          if (flag_bus.In_Clear) begin
            state_q  <= StIdle;
            stop_q   <= 1'b1;
            active_q <= 1'b0;
            armed_q  <= 1'b0;
          end else if (hcnt_q == HOLD_LAST) begin
            state_q  <= StIdle;
            stop_q   <= 1'b1;
            active_q <= 1'b0;
          end else if (sts) begin
            state_q <= StActive;
            hcnt_q  <= '0;
          end else begin
            hcnt_q <= hcnt_q + 28'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign flag_bus.Out_Start_Light     = start_q;
  assign flag_bus.Out_Stop_Extinguish = stop_q;
  assign flag_bus.Out_Flag_Active     = active_q;
  assign flag_bus.Out_Event_Cnt       = event_cnt_q;
endmodule

// File: tb/tb_flag_event_gen.sv
// Testbench for flag_event_gen with QUAL_CYCLES=4 and HOLD_CYCLES=10.
// The reference model tracks the lit/armed status and edge timestamps.
module tb_flag_event_gen;
  localparam int CNT_W = 16;
  localparam int QI    = 4;
  localparam int HI    = 10;
`ifdef FLAG_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic Clk_In = 1'b0;
  logic Rst_N  = 1'b0;
  always #5 Clk_In = ~Clk_In;

  flag_event_gen_if #(.CNT_W(CNT_W)) bus ();

  flag_event_gen #(
    .QUAL_CYCLES (16'(QI)),
    .HOLD_CYCLES (28'(HI)),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk_In   (Clk_In),
    .Rst_N    (Rst_N),
    .flag_bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: status delay line, lit/armed flags, edge timestamps
  int cyc;
  bit m_s1, m_s2, m_lit, m_armed, m_hold, m_qual, e_start, e_stop;
  int m_drop, m_rise, m_cnt;
  int obs_starts, obs_stops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lit = 0; m_armed = 1; m_hold = 0; m_qual = 0;
    m_cnt = 0; e_start = 0; e_stop = 0; cyc = 0; m_drop = 0; m_rise = 0;
  endtask

  task automatic model_edge(input bit st, input bit clr);
    bit s;
    s = m_s2; m_s2 = m_s1; m_s1 = st;
    e_start = 0; e_stop = 0;
    if (m_lit) begin
      if (clr) begin
        e_stop = 1; m_lit = 0; m_armed = 0;
      end else if (m_hold && (cyc - m_drop == HI)) begin
        e_stop = 1; m_lit = 0;
      end else if (s) begin
        m_hold = 0;
      end else if (!m_hold && !STICKY) begin
        m_hold = 1; m_drop = cyc;
      end
    end else if (!s) begin
      m_armed = 1; m_qual = 0;
    end else if (m_armed) begin
      if (!m_qual) begin
        m_qual = 1; m_rise = cyc;
      end else if (cyc - m_rise == QI) begin
        e_start = 1; m_lit = 1; m_qual = 0; m_hold = 0;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
    cyc++;
  endtask

  // Called at a negedge: drive, clock once, compare at the next negedge
  task automatic step(input bit st, input bit clr);
    bus.In_Status = st;
    bus.In_Clear  = clr;
    @(posedge Clk_In);
    model_edge(st, clr);
    @(negedge Clk_In);
    check("start", 32'(bus.Out_Start_Light), 32'(e_start));
    check("stop", 32'(bus.Out_Stop_Extinguish), 32'(e_stop));
    check("active", 32'(bus.Out_Flag_Active), 32'(m_lit));
    check("event_cnt", 32'(bus.Out_Event_Cnt), 32'(m_cnt));
    obs_starts += int'(bus.Out_Start_Light);
    obs_stops  += int'(bus.Out_Stop_Extinguish);
  endtask

  initial begin
    bit st;
    int run;
    bus.In_Status = 1'b0;
    bus.In_Clear  = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk_In);
    check("rst_start", 32'(bus.Out_Start_Light), 0);
    check("rst_stop", 32'(bus.Out_Stop_Extinguish), 0);
    check("rst_active", 32'(bus.Out_Flag_Active), 0);
    check("rst_cnt", 32'(bus.Out_Event_Cnt), 0);
    Rst_N = 1'b1;

    // 1: a short glitch never qualifies
    obs_starts = 0;
    repeat (3) step(1, 0);
    repeat (8) step(0, 0);
    check("t1_no_start", 32'(obs_starts), 0);
    check("t1_cnt", 32'(bus.Out_Event_Cnt), 0);

    // 2: held high, so the start appears on the 7th step (spec edge 7)
    for (int i = 0; i < 12; i++) begin
      step(1, 0);
      if (i == 6) check("t2_start_at_edge7", 32'(bus.Out_Start_Light), 1);
    end
    check("t2_active", 32'(bus.Out_Flag_Active), 1);
    check("t2_cnt", 32'(bus.Out_Event_Cnt), 1);

    // 3: drop; HOLD entered at step 2, so expiry lands on step 12
    obs_stops = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0);
      if (i == 12) check("t3_stop_at_hold10", 32'(bus.Out_Stop_Extinguish), STICKY ? 0 : 1);
    end
    check("t3_stops", 32'(obs_stops), STICKY ? 0 : 1);
    check("t3_active", 32'(bus.Out_Flag_Active), STICKY ? 1 : 0);
    if (STICKY) step(0, 1);

    // 4: re-light, then a 5-cycle drop retriggers with no pulses
    repeat (8) step(1, 0);
    obs_starts = 0; obs_stops = 0;
    repeat (5) step(0, 0);
    repeat (10) step(1, 0);
    check("t4_no_start", 32'(obs_starts), 0);
    check("t4_no_stop", 32'(obs_stops), 0);
    check("t4_active", 32'(bus.Out_Flag_Active), 1);

    // 5: clear while active; no restart until status is seen low
    obs_starts = 0; obs_stops = 0;
    step(1, 1);
    repeat (12) step(1, 0);
    check("t5_one_stop", 32'(obs_stops), 1);
    check("t5_no_restart", 32'(obs_starts), 0);
    repeat (3) step(0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      if (i == 6) check("t5_restart_7_after", 32'(bus.Out_Start_Light), 1);
    end

    // 6: clear coincident with hold expiry gives a single stop
    obs_stops = 0;
    for (int i = 0; i < 20; i++) step(0, bit'(m_lit && m_hold && (cyc - m_drop == HI)));
    if (m_lit) step(0, 1);
    check("t6_one_stop", 32'(obs_stops), 1);
    repeat (3) step(0, 0);

    // Reset mid-operation: everything drops with no stop pulse
    repeat (8) step(1, 0);
    Rst_N = 1'b0;
    #1;
    check("midrst_stop", 32'(bus.Out_Stop_Extinguish), 0);
    check("midrst_active", 32'(bus.Out_Flag_Active), 0);
    check("midrst_cnt", 32'(bus.Out_Event_Cnt), 0);
    bus.In_Status = 1'b0;
    @(negedge Clk_In);
    Rst_N = 1'b1;
    model_reset();

    // Random runs of status with sparse clears
    st = 1'b0;
    for (int n = 0; n < 80; n++) begin
      st = ~st;
      run = int'($urandom_range(1, 16));
      for (int k = 0; k < run; k++) step(st, ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
